// File: rtl/serial_tx_framer.sv
// serial_tx_framer: framed LSB-first serial transmitter with a one-word
// holding buffer and back-to-back frame support.
// Frame: start bit (1), DATA_W payload bits, optional even parity bit,
// GAP_BITS low bit periods. Each bit lasts BIT_CYC clock cycles.
// Optional feature macro: SERIAL_TX_PARITY_EN (adds the even-parity bit).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line low, waiting for a held word to transfer
// START  | driving the start bit (1)
// DATA   | driving shifter[0], one payload bit per bit period
// PARITY | driving even parity of the payload (SERIAL_TX_PARITY_EN)
// GAP    | driving low for GAP_BITS bit periods between frames

module serial_tx_framer #(
  parameter int DATA_W   = 55,
  parameter int BIT_CYC  = 1,
  parameter int GAP_BITS = 2
) (
  input  logic              Clk_S,
  input  logic              Rst_n,
  input  logic [DATA_W-1:0] TX_Data,
  input  logic              TX_Data_Valid,
  output logic              TX_Ready,
  output logic              S_Data,
  output logic              TX_Busy
);

  localparam int BIT_W = (DATA_W   > 1) ? $clog2(DATA_W)   : 1;
  localparam int CYC_W = (BIT_CYC  > 1) ? $clog2(BIT_CYC)  : 1;
  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_GAP    = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_GAP    = 3'd4
  } state_t;
`endif

  state_t              r_state;
  logic [DATA_W-1:0]   r_hold;
  logic                r_hold_full;
  logic [DATA_W-1:0]   r_shift;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [CYC_W-1:0]    r_cyc_cnt;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic                r_s_data;
`ifdef SERIAL_TX_PARITY_EN
  logic                r_parity;
`endif

  logic                w_bit_end;
  logic                w_accept;

  // Bit boundary and handshake decode, all from flop state plus valid
  always_comb begin
    w_bit_end = (r_cyc_cnt == CYC_LAST);
    w_accept  = TX_Data_Valid & ~r_hold_full;
  end

  // Framing FSM: holding buffer, shifter, counters and registered line
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_cyc_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_s_data    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      // Accept and transfer are mutually exclusive on hold_full, so the
      // transfer's clear below never races with this set.
      if (w_accept) begin
        r_hold      <= TX_Data;
        r_hold_full <= 1'b1;
      end

      if (r_state != S_IDLE) begin
        if (w_bit_end) begin
          r_cyc_cnt <= '0;
        end else begin
          r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          r_s_data <= 1'b0;
          if (r_hold_full) begin
            r_shift     <= r_hold;
`ifdef SERIAL_TX_PARITY_EN
            r_parity    <= ^r_hold;
`endif
            r_hold_full <= 1'b0;
            r_bit_cnt   <= '0;
            r_cyc_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_state     <= S_START;
            r_s_data    <= 1'b1;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_state  <= S_DATA;
            r_s_data <= r_shift[0];
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
              r_gap_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
              r_state   <= S_PARITY;
              r_s_data  <= r_parity;
`else
              r_state   <= S_GAP;
              r_s_data  <= 1'b0;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
              r_shift   <= r_shift >> 1;
              // Line is registered, so it takes the bit that becomes
              // shifter[0] after this shift.
              r_s_data  <= r_shift[1];
            end
          end
        end

`ifdef SERIAL_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_state   <= S_GAP;
            r_gap_cnt <= '0;
            r_s_data  <= 1'b0;
          end
        end
`endif

        S_GAP: begin
          if (w_bit_end) begin
            if (r_gap_cnt == GAP_LAST) begin
              r_gap_cnt <= '0;
              if (r_hold_full) begin
                // Back-to-back: next start bit follows the last gap bit
                r_shift     <= r_hold;
`ifdef SERIAL_TX_PARITY_EN
                r_parity    <= ^r_hold;
`endif
                r_hold_full <= 1'b0;
                r_bit_cnt   <= '0;
                r_cyc_cnt   <= '0;
                r_state     <= S_START;
                r_s_data    <= 1'b1;
              end else begin
                r_state  <= S_IDLE;
                r_s_data <= 1'b0;
              end
            end else begin
              r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_s_data <= 1'b0;
        end
      endcase
    end
  end

  assign TX_Ready = ~r_hold_full;
  assign S_Data   = r_s_data;
  assign TX_Busy  = (r_state != S_IDLE) | r_hold_full;

endmodule

// File: tb/tb_serial_tx_framer.sv
// Directed testbench for serial_tx_framer. Three instances cover the
// 8-bit / 1-cycle, 8-bit / 3-cycle and 55-bit / 1-gap configurations.
// Expected line values follow the frame definition; parity presence
// tracks SERIAL_TX_PARITY_EN.

module tb_serial_tx_framer;

`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  localparam int LA = 1 + 8 + PAR + 2;   // frame bits, instance A and B
  localparam int LC = 1 + 55 + PAR + 1;  // frame bits, instance C

  logic        Clk_S;
  logic        Rst_n;

  logic [7:0]  a_data;
  logic        a_valid, a_ready, a_s, a_busy;
  logic [7:0]  b_data;
  logic        b_valid, b_ready, b_s, b_busy;
  logic [54:0] c_data;
  logic        c_valid, c_ready, c_s, c_busy;

  int checks = 0;
  int errors = 0;

  serial_tx_framer #(.DATA_W(8), .BIT_CYC(1), .GAP_BITS(2)) u_a (
    .Clk_S(Clk_S), .Rst_n(Rst_n), .TX_Data(a_data), .TX_Data_Valid(a_valid),
    .TX_Ready(a_ready), .S_Data(a_s), .TX_Busy(a_busy));

  serial_tx_framer #(.DATA_W(8), .BIT_CYC(3), .GAP_BITS(2)) u_b (
    .Clk_S(Clk_S), .Rst_n(Rst_n), .TX_Data(b_data), .TX_Data_Valid(b_valid),
    .TX_Ready(b_ready), .S_Data(b_s), .TX_Busy(b_busy));

  serial_tx_framer #(.DATA_W(55), .BIT_CYC(1), .GAP_BITS(1)) u_c (
    .Clk_S(Clk_S), .Rst_n(Rst_n), .TX_Data(c_data), .TX_Data_Valid(c_valid),
    .TX_Ready(c_ready), .S_Data(c_s), .TX_Busy(c_busy));

  initial begin
    Clk_S = 1'b0;
    forever #5 Clk_S = ~Clk_S;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Line value for bit period n of a frame carrying d (dw payload bits)
  function automatic logic exp_line(input logic [63:0] d, input int dw, input int n);
    if (n == 0) return 1'b1;
    if (n <= dw) return d[n-1];
    if (PAR == 1 && n == dw + 1) return ^d;
    return 1'b0;
  endfunction

  logic [7:0] w3;
  logic       e;

  initial begin
    Rst_n   = 1'b0;
    a_data  = '0; a_valid = 1'b0;
    b_data  = '0; b_valid = 1'b0;
    c_data  = '0; c_valid = 1'b0;

    // Reset values
    #3;
    chk("rst_s",     a_s,     1'b0);
    chk("rst_ready", a_ready, 1'b1);
    chk("rst_busy",  a_busy,  1'b0);
    @(negedge Clk_S);
    Rst_n = 1'b1;
    @(negedge Clk_S);

    // Single frame 0xA5 on A
    a_data = 8'hA5; a_valid = 1'b1;
    @(negedge Clk_S);
    chk("a5_ready_low", a_ready, 1'b0);
    chk("a5_busy",      a_busy,  1'b1);
    chk("a5_line_pre",  a_s,     1'b0);
    a_valid = 1'b0;
    for (int n = 0; n < LA; n++) begin
      @(negedge Clk_S);
      chk($sformatf("a5_s[%0d]", n), a_s, exp_line(64'hA5, 8, n));
      if (n == 0) chk("a5_ready_back", a_ready, 1'b1);
    end
    @(negedge Clk_S);
    chk("a5_idle_s",    a_s,    1'b0);
    chk("a5_idle_busy", a_busy, 1'b0);

    // Bit period: 0x01 on B, 3 cycles per bit
    b_data = 8'h01; b_valid = 1'b1;
    @(negedge Clk_S);
    b_valid = 1'b0;
    for (int c = 0; c < LA * 3; c++) begin
      @(negedge Clk_S);
      chk($sformatf("bp_s[%0d]", c), b_s, exp_line(64'h01, 8, c / 3));
    end
    @(negedge Clk_S);
    chk("bp_idle_busy", b_busy, 1'b0);

    // Back-to-back 0x0F then 0xF0 on A
    a_data = 8'h0F; a_valid = 1'b1;
    @(negedge Clk_S);
    a_data = 8'hF0;
    for (int n = 0; n < 2 * LA; n++) begin
      @(negedge Clk_S);
      e = (n < LA) ? exp_line(64'h0F, 8, n) : exp_line(64'hF0, 8, n - LA);
      chk($sformatf("b2b_s[%0d]", n), a_s, e);
      chk($sformatf("b2b_ready[%0d]", n), a_ready, (n == 0 || n >= LA));
      chk($sformatf("b2b_busy[%0d]", n), a_busy, 1'b1);
      if (n == 1) a_valid = 1'b0;
    end
    @(negedge Clk_S);
    chk("b2b_idle_busy", a_busy, 1'b0);

    // Backpressure: data changes every cycle while the buffer is full
    a_data = 8'h11; a_valid = 1'b1;
    @(negedge Clk_S);
    a_data = 8'h3C;
    w3 = 8'h80 + 8'(LA);
    for (int n = 0; n < 3 * LA; n++) begin
      @(negedge Clk_S);
      if (n < LA)            e = exp_line(64'h11, 8, n);
      else if (n < 2 * LA)   e = exp_line(64'h3C, 8, n - LA);
      else                   e = exp_line(64'(w3), 8, n - 2 * LA);
      chk($sformatf("bkp_s[%0d]", n), a_s, e);
      chk($sformatf("bkp_ready[%0d]", n), a_ready,
          (n == 0 || n == LA || n >= 2 * LA));
      if (n >= 1 && n <= LA) a_data = 8'h80 + 8'(n);
      if (n == LA + 1) a_valid = 1'b0;
    end
    @(negedge Clk_S);
    chk("bkp_idle_busy", a_busy, 1'b0);

    // Width: 55-bit word with bits 0 and 54 set on C
    c_data = 55'h40_0000_0000_0001; c_valid = 1'b1;
    @(negedge Clk_S);
    c_valid = 1'b0;
    for (int n = 0; n < LC; n++) begin
      @(negedge Clk_S);
      chk($sformatf("w55_s[%0d]", n), c_s, exp_line(64'h40_0000_0000_0001, 55, n));
    end
    @(negedge Clk_S);
    chk("w55_idle_busy", c_busy, 1'b0);
    chk("w55_idle_s",    c_s,    1'b0);

    // Reset mid-DATA with a second word held
    a_data = 8'hFF; a_valid = 1'b1;
    @(negedge Clk_S);
    @(negedge Clk_S);
    @(negedge Clk_S);
    chk("mid_ready_low", a_ready, 1'b0);
    chk("mid_s_d0",      a_s,     1'b1);
    a_valid = 1'b0;
    @(negedge Clk_S);
    chk("mid_s_d1", a_s,    1'b1);
    chk("mid_busy", a_busy, 1'b1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_s",     a_s,     1'b0);
    chk("arst_ready", a_ready, 1'b1);
    chk("arst_busy",  a_busy,  1'b0);
    @(negedge Clk_S);
    Rst_n = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(negedge Clk_S);
      chk($sformatf("post_rst_s[%0d]", n), a_s, 1'b0);
      chk($sformatf("post_rst_busy[%0d]", n), a_busy, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx_framer.md
# serial_tx_framer

Parametrised serial transmitter for the token-based router links: accepts a `DATA_W`-bit word over a valid/ready handshake and shifts it out LSB-first on a single wire as a framed packet (start bit, data, optional parity, inter-frame gap). It replaces the fixed 55-bit transmitter path with these additions:
- configurable width and bit period;
- a one-word holding buffer, so the next word can be accepted while the current frame is on the wire;
- back-to-back frames with no idle cycle between them.

## Interface
Parameters:
- `DATA_W`, default 55: payload bits per frame; legal range 2..64.
- `BIT_CYC`, default 1: `Clk_S` cycles each serial bit is held; legal range 1..16.
- `GAP_BITS`, default 2: low bit periods appended after each frame; legal range 1..8.

Ports (one clock; reset is asynchronous and active-low):
- `Clk_S`, in, 1: link clock; all flops rise-edge.
- `Rst_n`, in, 1: asynchronous active-low reset.
- `TX_Data`, in, `DATA_W`: payload word, sampled on accept.
- `TX_Data_Valid`, in, 1: producer has a word on `TX_Data`.
- `TX_Ready`, out, 1: holding buffer empty; the block can accept a word.
- `S_Data`, out, 1: serial line, registered output, idles low.
- `TX_Busy`, out, 1: high while a frame is in flight or the holding buffer is full.

## Operation
- **Accept.** A word is accepted on a rising edge where `TX_Data_Valid` and `TX_Ready` are both 1. `TX_Data` is copied into the holding register (`hold_full` is set).
- **TX_Ready.** `TX_Ready` = !`hold_full`. It depends only on flop state, with no combinational path from `TX_Data_Valid`. When ready is low, `TX_Data_Valid` is ignored and the producer holds its data.
- **State machine states:** IDLE, START, DATA, PARITY, GAP.
- **Transfer.** From IDLE with `hold_full`=1, the next edge does all of the following:
  - moves the holding register into the shifter and clears `hold_full`;
  - enters START;
  - loads `bit_cnt`=0 and `cyc_cnt`=0.
- **Per-state line values:**
  - START drives `S_Data`=1.
  - DATA drives `shifter[0]`. The shifter shifts right at each bit boundary; `bit_cnt` counts 0..`DATA_W`-1.
  - PARITY drives even parity: XOR of all `DATA_W` payload bits, computed at load time.
  - GAP drives `S_Data`=0 for `GAP_BITS` bit periods.
- **Bit boundary.** A boundary occurs when `cyc_cnt`=`BIT_CYC`-1; `cyc_cnt` then wraps to 0.
- **State transitions:**
  - START→DATA after 1 bit.
  - DATA→PARITY after the last data bit (→GAP when parity is compiled out).
  - PARITY→GAP after 1 bit.
  - On the last GAP boundary: if `hold_full`=1, go to START with the transfer performed on the same edge (back-to-back); otherwise go to IDLE.
- **Simultaneous accept and transfer.** These cannot collide, because accept needs `hold_full`=0 and transfer needs `hold_full`=1. A word accepted on the same edge as the last-GAP boundary is not transferred until the next edge. It therefore starts one cycle later via the IDLE→START path.
- **Counters.** `bit_cnt` is `$clog2(DATA_W)` bits wide and `cyc_cnt` is `$clog2(BIT_CYC)` bits wide (minimum 1 bit each). Neither counter ever exceeds its terminal value.
- **TX_Busy** = (state≠IDLE) | `hold_full`.

## Timing
- **Reset values**, asserted asynchronously while `Rst_n`=0:
  - `S_Data`=0, `TX_Ready`=1, `TX_Busy`=0;
  - state=IDLE, `hold_full`=0, counters=0.
- **Reset mid-frame.** The frame and any held word are discarded. The line drops low immediately, without waiting for a clock edge.
- **Latency.** Accept at edge k, with the block IDLE:
  - `TX_Ready` falls after edge k;
  - the transfer occurs at edge k+1, when `S_Data` goes 1 (start bit) and `TX_Ready` rises again.
- **Frame length** = (1 + `DATA_W` + P + `GAP_BITS`) × `BIT_CYC` cycles, where P=1 with parity and 0 without. Default (parity on): 59 cycles.
- **Throughput.** Back-to-back streaming with a continuously valid producer yields exactly one frame per frame length, with no IDLE cycles between frames.

## Configuration
- Feature macro: `SERIAL_TX_PARITY_EN`.
- **Defined:** the PARITY state exists and one even-parity bit follows the data.
- **Undefined:** the PARITY state and the parity logic are removed; DATA goes directly to GAP and frames are one bit period shorter.

## Test plan
- **Reset.** Assert `Rst_n`=0 mid-DATA → within the same cycle `S_Data`=0, `TX_Ready`=1, `TX_Busy`=0. After release, the line stays low until a new accept.
- **Single frame, parity on.** Settings: `DATA_W`=8, `BIT_CYC`=1, `GAP_BITS`=2. Send 0xA5 → from edge k+1, `S_Data` = 1, 1,0,1,0,0,1,0,1, 0 (parity), 0,0; then IDLE; 12 cycles total.
- **Bit period.** Settings: `BIT_CYC`=3, parity off, `DATA_W`=8. Send 0x01 → 3 cycles of 1 (start), 3 cycles of 1 (bit 0), 21 cycles of 0 (bits 1–7), then 6 gap cycles of 0.
- **Back-to-back.** Hold `TX_Data_Valid`=1 and send 0x0F then 0xF0 (`DATA_W`=8, parity on) → the second start bit immediately follows the second gap bit. `TX_Ready` is low from the second accept until the transfer edge.
- **Backpressure.** Assert valid while `hold_full`=1 and change `TX_Data` each cycle → no accept occurs. The word sampled is the one present on the edge where `TX_Ready` returns high.
- **Width.** Settings: `DATA_W`=55, `GAP_BITS`=1. Send 55'h40_0000_0000_0001 → data bits 0 and 54 are 1 and all others 0; parity=0; frame is 58 cycles.
